pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port stall_i  in  1  hazard hold from decode; blocks new fetch requests.
REQ-005 SHALL have port take_branch  in  1  EX-stage redirect request (branch taken or jump).
REQ-006 SHALL have port branch_target_NextPC  in  32  EX-stage redirect target.
REQ-007 SHALL have port imem_req_valid  out  1  instruction-memory request valid.
REQ-008 SHALL have port imem_req_ready  in  1  instruction-memory accepts request.
REQ-009 SHALL have port imem_addr  out  32  request address.
REQ-010 SHALL have port if_valid_o  out  1  registered pulse: one request accepted last cycle.
REQ-011 SHALL have port if_pc_o  out  32  registered PC of the accepted request.
REQ-012 SHALL have port flush_o  out  1  combinational kill of IF/ID and ID/EX on accepted redirect.
REQ-013 SHALL have port misalign_o  out  1  one-cycle pulse on misaligned redirect target.
REQ-014 SHALL have port misalign_addr_o  out  32  offending target, held until resume.
REQ-015 SHALL have port resume_i / resume_pc_i  in  1 / 32  leave HALT and fetch from resume_pc_i.
REQ-016 SHALL have port redirect_cnt_o  out  16  count of accepted redirects, wraps at 16'hFFFF->0.

Function
REQ-017 States SHALL be BOOT, FETCH, HOLD_REDIR and HALT; BOOT lasts exactly one cycle, then FETCH.
REQ-018 imem_req_valid SHALL be 1 only in FETCH/HOLD_REDIR, and then only when (!stall_i or pending_q), with pending_q = valid & !ready registered.
REQ-019 Once imem_req_valid is high without ready, imem_addr and valid SHALL stay stable until the handshake completes, regardless of stall_i or take_branch.
REQ-020 imem_addr SHALL equal pc_q; on handshake (valid&ready) in FETCH with no redirect, pc_q SHALL become pc_q+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 Handshake SHALL set if_valid_o=1 and if_pc_o=imem_addr next cycle; otherwise if_valid_o=0 and if_pc_o holds.
REQ-022 take_branch with target[1:0]==0 and no pending_q: flush_o=1 this cycle, pc_q<=target, redirect_cnt_o increments, state FETCH; the same-cycle handshake (if any) SHALL NOT raise if_valid_o.
REQ-023 take_branch with aligned target while pending_q=1: flush_o=1, target latched in redir_q, state HOLD_REDIR; counter increments.
REQ-024 In HOLD_REDIR the held request completes; on its handshake pc_q<=redir_q, if_valid_o stays 0, state FETCH.
REQ-025 A further take_branch in HOLD_REDIR SHALL overwrite redir_q (latest wins) and raise flush_o again.
REQ-026 Redirect priority SHALL exceed stall_i; stall_i never suppresses flush_o.
REQ-027 take_branch with target[1:0]!=0: misalign_o=1 one cycle, misalign_addr_o<=target, flush_o=1, counter unchanged, state HALT after any pending handshake (data discarded).
REQ-028 In HALT, imem_req_valid=0 and take_branch is ignored; resume_i loads pc_q<=resume_pc_i and goes FETCH next cycle.

Reset
REQ-029 rst_n=0 at a clock edge SHALL, in any state or mid-handshake: state BOOT, pc_q=RESET_PC, redir_q=0, pending_q=0, redirect_cnt_o=0, misalign_addr_o=0, if_pc_o=0, if_valid_o=0, misalign_o=0; imem_req_valid=0 and flush_o=0 while in BOOT.

Verification
REQ-030 Reset release, ready=1, no stall -> valid rises cycle 2, addresses 0,4,8,...; if_pc_o trails imem_addr by one cycle.
REQ-031 ready=0 for 3 cycles at addr 0x10 with stall_i=1 meanwhile -> addr 0x10 and valid stable until ready, then valid drops while stall_i=1.
REQ-032 take_branch, target 0x200, pending request at 0x20 -> flush_o pulse, HOLD_REDIR, 0x20 completes without if_valid_o, next addr 0x200, redirect_cnt_o=1.
REQ-033 take_branch, target 0x102 -> misalign_o pulse, misalign_addr_o=0x102, valid=0; resume_i with 0x400 -> next addr 0x400.
REQ-034 pc_q=0xFFFF_FFFC handshake -> next addr 0x0; 65536 redirects -> redirect_cnt_o=0; rst_n=0 during HOLD_REDIR -> all outputs at reset values.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch-address sequencer: issues imem requests, applies EX redirects, halts on misaligned targets.
// Latency: imem_addr/valid/flush_o combinational from state; if_valid_o/if_pc_o/misalign_o one cycle after the event.
// Backpressure: an issued-but-unaccepted request holds address and valid until imem_req_ready; stall_i only blocks new issues.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        take_branch,
    input  logic [31:0] branch_target_NextPC,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic        flush_o,
    output logic        misalign_o,
    output logic [31:0] misalign_addr_o,
    input  logic        resume_i,
    input  logic [31:0] resume_pc_i,
    output logic [15:0] redirect_cnt_o
);

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        FETCH      = 2'd1,
        HOLD_REDIR = 2'd2,
        HALT       = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic        halt_q, halt_d;
    logic        pending_q, pending_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] maddr_q, maddr_d;
    logic        mis_q, mis_d;
    logic        ifv_q, ifv_d;
    logic [31:0] ifpc_q, ifpc_d;

    logic active, hs, held, redir_acc, tgt_mis;

    assign active         = (state_q == FETCH) || (state_q == HOLD_REDIR);
    assign imem_req_valid = active && (!stall_i || pending_q);
    assign imem_addr      = pc_q;
    assign hs             = imem_req_valid && imem_req_ready;
    assign held           = imem_req_valid && !imem_req_ready;
    assign redir_acc      = active && take_branch;
    assign tgt_mis        = branch_target_NextPC[1:0] != 2'b00;
    assign flush_o        = redir_acc;

    assign if_valid_o      = ifv_q;
    assign if_pc_o         = ifpc_q;
    assign misalign_o      = mis_q;
    assign misalign_addr_o = maddr_q;
    assign redirect_cnt_o  = cnt_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        redir_d   = redir_q;
        halt_d    = halt_q;
        cnt_d     = cnt_q;
        maddr_d   = maddr_q;
        mis_d     = 1'b0;
        ifv_d     = 1'b0;
        ifpc_d    = ifpc_q;
        pending_d = held;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                // A request left outstanding this cycle must keep its address,
                // so the redirect is parked in redir_q until it completes.
                if (redir_acc) begin
                    if (tgt_mis) begin
                        mis_d   = 1'b1;
                        maddr_d = branch_target_NextPC;
                        halt_d  = 1'b1;
                        state_d = held ? HOLD_REDIR : HALT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        if (held) begin
                            redir_d = branch_target_NextPC;
                            halt_d  = 1'b0;
                            state_d = HOLD_REDIR;
                        end else begin
                            pc_d = branch_target_NextPC;
                        end
                    end
                end else if (hs) begin
                    pc_d   = pc_q + 32'd4;
                    ifv_d  = 1'b1;
                    ifpc_d = pc_q;
                end
            end
            HOLD_REDIR: begin
                if (redir_acc) begin
                    if (tgt_mis) begin
                        mis_d   = 1'b1;
                        maddr_d = branch_target_NextPC;
                        halt_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                        redir_d = branch_target_NextPC;
                        halt_d  = 1'b0;
                    end
                end
                // The held request's data belongs to the squashed path.
                if (hs) begin
                    if (halt_d) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = redir_d;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                if (resume_i) begin
                    pc_d    = resume_pc_i;
                    halt_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            redir_q   <= 32'd0;
            halt_q    <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= 16'd0;
            maddr_q   <= 32'd0;
            mis_q     <= 1'b0;
            ifv_q     <= 1'b0;
            ifpc_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            redir_q   <= redir_d;
            halt_q    <= halt_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            maddr_q   <= maddr_d;
            mis_q     <= mis_d;
            ifv_q     <= ifv_d;
            ifpc_q    <= ifpc_d;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed vector table plus hand sequences for reset-in-HOLD_REDIR and counter wrap.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        take_branch;
    logic [31:0] branch_target_NextPC;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic        flush_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
    logic        resume_i;
    logic [31:0] resume_pc_i;
    logic [15:0] redirect_cnt_o;

    int checks = 0;
    int errors = 0;

    pc_redirect_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stall_i              (stall_i),
        .take_branch          (take_branch),
        .branch_target_NextPC (branch_target_NextPC),
        .imem_req_valid       (imem_req_valid),
        .imem_req_ready       (imem_req_ready),
        .imem_addr            (imem_addr),
        .if_valid_o           (if_valid_o),
        .if_pc_o              (if_pc_o),
        .flush_o              (flush_o),
        .misalign_o           (misalign_o),
        .misalign_addr_o      (misalign_addr_o),
        .resume_i             (resume_i),
        .resume_pc_i          (resume_pc_i),
        .redirect_cnt_o       (redirect_cnt_o)
    );

    always #5 clk = ~clk;

    // Inputs applied for one cycle; e_vld/e_addr/e_flush seen before the edge,
    // the rest seen just after it.
    typedef struct {
        logic [31:0] stall, tb, tgt, rdy, res, rpc;
        logic [31:0] e_vld, e_addr, e_flush;
        logic [31:0] e_ifv, e_ifpc, e_mis, e_maddr, e_cnt;
    } vec_t;

    localparam int NV = 38;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] ifv, input logic [31:0] ifpc,
                            input logic [31:0] mis, input logic [31:0] maddr, input logic [31:0] cnt);
        chk({tag, " if_valid_o"}, 32'(if_valid_o), ifv);
        chk({tag, " if_pc_o"}, if_pc_o, ifpc);
        chk({tag, " misalign_o"}, 32'(misalign_o), mis);
        chk({tag, " misalign_addr_o"}, misalign_addr_o, maddr);
        chk({tag, " redirect_cnt_o"}, 32'(redirect_cnt_o), cnt);
    endtask

    initial begin
        //            stall tb tgt        rdy res rpc           vld addr        fl  ifv ifpc        mis maddr  cnt
        tbl[0]  = '{0, 0, 0,          1, 0, 0,              0, 'h0,         0,  0, 'h0,         0, 0,     0};
        tbl[1]  = '{0, 0, 0,          1, 0, 0,              1, 'h0,         0,  1, 'h0,         0, 0,     0};
        tbl[2]  = '{0, 0, 0,          1, 0, 0,              1, 'h4,         0,  1, 'h4,         0, 0,     0};
        tbl[3]  = '{0, 0, 0,          1, 0, 0,              1, 'h8,         0,  1, 'h8,         0, 0,     0};
        tbl[4]  = '{0, 0, 0,          1, 0, 0,              1, 'hC,         0,  1, 'hC,         0, 0,     0};
        tbl[5]  = '{0, 0, 0,          0, 0, 0,              1, 'h10,        0,  0, 'hC,         0, 0,     0};
        tbl[6]  = '{1, 0, 0,          0, 0, 0,              1, 'h10,        0,  0, 'hC,         0, 0,     0};
        tbl[7]  = '{1, 0, 0,          0, 0, 0,              1, 'h10,        0,  0, 'hC,         0, 0,     0};
        tbl[8]  = '{1, 0, 0,          1, 0, 0,              1, 'h10,        0,  1, 'h10,        0, 0,     0};
        tbl[9]  = '{1, 0, 0,          1, 0, 0,              0, 'h14,        0,  0, 'h10,        0, 0,     0};
        tbl[10] = '{0, 0, 0,          1, 0, 0,              1, 'h14,        0,  1, 'h14,        0, 0,     0};
        tbl[11] = '{0, 0, 0,          1, 0, 0,              1, 'h18,        0,  1, 'h18,        0, 0,     0};
        tbl[12] = '{0, 0, 0,          1, 0, 0,              1, 'h1C,        0,  1, 'h1C,        0, 0,     0};
        tbl[13] = '{0, 0, 0,          0, 0, 0,              1, 'h20,        0,  0, 'h1C,        0, 0,     0};
        tbl[14] = '{0, 1, 'h200,      0, 0, 0,              1, 'h20,        1,  0, 'h1C,        0, 0,     1};
        tbl[15] = '{1, 0, 0,          0, 0, 0,              1, 'h20,        0,  0, 'h1C,        0, 0,     1};
        tbl[16] = '{0, 0, 0,          1, 0, 0,              1, 'h20,        0,  0, 'h1C,        0, 0,     1};
        tbl[17] = '{0, 0, 0,          1, 0, 0,              1, 'h200,       0,  1, 'h200,       0, 0,     1};
        tbl[18] = '{0, 0, 0,          0, 0, 0,              1, 'h204,       0,  0, 'h200,       0, 0,     1};
        tbl[19] = '{0, 1, 'h300,      0, 0, 0,              1, 'h204,       1,  0, 'h200,       0, 0,     2};
        tbl[20] = '{0, 1, 'h340,      0, 0, 0,              1, 'h204,       1,  0, 'h200,       0, 0,     3};
        tbl[21] = '{0, 0, 0,          1, 0, 0,              1, 'h204,       0,  0, 'h200,       0, 0,     3};
        tbl[22] = '{0, 0, 0,          1, 0, 0,              1, 'h340,       0,  1, 'h340,       0, 0,     3};
        tbl[23] = '{0, 1, 'h500,      1, 0, 0,              1, 'h344,       1,  0, 'h340,       0, 0,     4};
        tbl[24] = '{0, 0, 0,          1, 0, 0,              1, 'h500,       0,  1, 'h500,       0, 0,     4};
        tbl[25] = '{1, 1, 'h600,      1, 0, 0,              0, 'h504,       1,  0, 'h500,       0, 0,     5};
        tbl[26] = '{0, 0, 0,          1, 0, 0,              1, 'h600,       0,  1, 'h600,       0, 0,     5};
        tbl[27] = '{1, 1, 'h102,      1, 0, 0,              0, 'h604,       1,  0, 'h600,       1, 'h102, 5};
        tbl[28] = '{0, 1, 'h800,      1, 0, 0,              0, 'h604,       0,  0, 'h600,       0, 'h102, 5};
        tbl[29] = '{0, 0, 0,          1, 1, 'h400,          0, 'h604,       0,  0, 'h600,       0, 'h102, 5};
        tbl[30] = '{0, 0, 0,          1, 0, 0,              1, 'h400,       0,  1, 'h400,       0, 'h102, 5};
        tbl[31] = '{0, 0, 0,          0, 0, 0,              1, 'h404,       0,  0, 'h400,       0, 'h102, 5};
        tbl[32] = '{0, 1, 'h7,        0, 0, 0,              1, 'h404,       1,  0, 'h400,       1, 'h7,   5};
        tbl[33] = '{0, 0, 0,          1, 0, 0,              1, 'h404,       0,  0, 'h400,       0, 'h7,   5};
        tbl[34] = '{0, 0, 0,          1, 0, 0,              0, 'h404,       0,  0, 'h400,       0, 'h7,   5};
        tbl[35] = '{0, 0, 0,          1, 1, 'hFFFF_FFFC,    0, 'h404,       0,  0, 'h400,       0, 'h7,   5};
        tbl[36] = '{0, 0, 0,          1, 0, 0,              1, 'hFFFF_FFFC, 0,  1, 'hFFFF_FFFC, 0, 'h7,   5};
        tbl[37] = '{0, 0, 0,          1, 0, 0,              1, 'h0,         0,  1, 'h0,         0, 'h7,   5};

        rst_n = 1'b0;
        stall_i = 1'b0;
        take_branch = 1'b0;
        branch_target_NextPC = 32'd0;
        imem_req_ready = 1'b0;
        resume_i = 1'b0;
        resume_pc_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", 32'(imem_req_valid), 32'd0);
        chk("reset flush", 32'(flush_o), 32'd0);
        chk_regs("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall_i              = tbl[i].stall[0];
            take_branch          = tbl[i].tb[0];
            branch_target_NextPC = tbl[i].tgt;
            imem_req_ready       = tbl[i].rdy[0];
            resume_i             = tbl[i].res[0];
            resume_pc_i          = tbl[i].rpc;
            #1;
            chk($sformatf("v%0d imem_req_valid", i), 32'(imem_req_valid), tbl[i].e_vld);
            chk($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d flush_o", i), 32'(flush_o), tbl[i].e_flush);
            @(posedge clk);
            #1;
            chk_regs($sformatf("v%0d", i), tbl[i].e_ifv, tbl[i].e_ifpc,
                     tbl[i].e_mis, tbl[i].e_maddr, tbl[i].e_cnt);
        end

        // Park a redirect behind an unaccepted request, then reset mid-handshake.
        stall_i = 1'b0; take_branch = 1'b0; resume_i = 1'b0; imem_req_ready = 1'b0;
        @(posedge clk); #1;
        take_branch = 1'b1; branch_target_NextPC = 32'h800;
        #1;
        chk("hold flush", 32'(flush_o), 32'd1);
        chk("hold addr", imem_addr, 32'h4);
        @(posedge clk); #1;
        chk("hold cnt", 32'(redirect_cnt_o), 32'd6);
        chk("hold valid", 32'(imem_req_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst-hold valid", 32'(imem_req_valid), 32'd0);
        chk("rst-hold flush", 32'(flush_o), 32'd0);
        chk("rst-hold addr", imem_addr, 32'h0);
        chk_regs("rst-hold", 0, 0, 0, 0, 0);

        // Counter wrap: 65536 aligned redirects from zero.
        rst_n = 1'b1; stall_i = 1'b1; take_branch = 1'b0;
        @(posedge clk); #1;
        take_branch = 1'b1; branch_target_NextPC = 32'h40;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap flush", 32'(flush_o), 32'd1);
        chk("cnt 65535", 32'(redirect_cnt_o), 32'hFFFF);
        @(posedge clk); #1;
        chk("cnt wrap", 32'(redirect_cnt_o), 32'h0);
        chk("wrap addr", imem_addr, 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
